// File: rtl/draw_pkg.sv
// Shared screen geometry, field widths and the box-request record used by the
// plot pipeline.
package draw_pkg;

  localparam int X_W   = 8;
  localparam int Y_W   = 7;
  localparam int COL_W = 3;
  localparam int REQ_W = X_W + Y_W + COL_W;

  localparam int X_MAX = 159;
  localparam int Y_MAX = 119;

  localparam logic [COL_W-1:0] WHITE = 3'b111;
  localparam logic [COL_W-1:0] BLACK = 3'b000;

  typedef struct packed {
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [COL_W-1:0] colour;
  } box_req_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_DRAW = 1'b1
  } draw_state_t;

endpackage

// File: rtl/box_plot_sink_if.sv
// Request stream into the box plotter plus the pixel write port it drives
// toward the VGA adapter.
interface box_plot_sink_if;

  // Handshake: a request transfers on any clk edge where req_valid && req_ready.
  // req_ready reflects only buffer space, never a same-cycle drain.
  logic                      req_valid;
  logic                      req_ready;
  logic [draw_pkg::X_W-1:0]   req_x;
  logic [draw_pkg::Y_W-1:0]   req_y;
  logic [draw_pkg::COL_W-1:0] req_colour;

  logic [draw_pkg::X_W-1:0]   vga_x;
  logic [draw_pkg::Y_W-1:0]   vga_y;
  logic [draw_pkg::COL_W-1:0] vga_colour;
  logic                      vga_plot;

  modport master (
    output req_valid, req_x, req_y, req_colour,
    input  req_ready, vga_x, vga_y, vga_colour, vga_plot
  );

  modport slave (
    input  req_valid, req_x, req_y, req_colour,
    output req_ready, vga_x, vga_y, vga_colour, vga_plot
  );

endinterface

// File: rtl/plot_req_fifo.sv
// Small synchronous FIFO holding pending box requests; head is read
// combinationally so a pop can load the working registers on the same edge.
module plot_req_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/box_plot_sink.sv
// Buffers box-draw requests and rasterises each one into BOX_W x BOX_H
// single-pixel writes, one per clock, clipping anything off screen.
module box_plot_sink
  import draw_pkg::*;
#(
    parameter int BOX_W      = 4,
    parameter int BOX_H      = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int X_MAX      = draw_pkg::X_MAX,
    parameter int Y_MAX      = draw_pkg::Y_MAX
) (
    input  logic              clk,
    input  logic              resetn,
    box_plot_sink_if.slave    bus,
    output logic              busy,
    output logic [7:0]        clip_count,
    output draw_state_t       dbg_state
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    box_req_t          fifo_din;
    box_req_t          fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [CNT_W-1:0]  fifo_count;

    draw_state_t       state;
    draw_state_t       next_state;

    logic [X_W-1:0]    bx;
    logic [Y_W-1:0]    by;
    logic [COL_W-1:0]  bc;
    logic [2:0]        cx;
    logic [2:0]        cy;
    logic              last_x;
    logic              last_pix;
    logic [X_W:0]      sum_x;
    logic [Y_W:0]      sum_y;
    logic              on_screen;

    logic [X_W-1:0]    vga_x_r,   x_d;
    logic [Y_W-1:0]    vga_y_r,   y_d;
    logic [COL_W-1:0]  vga_col_r, col_d;
    logic              vga_plot_r, plot_d;
    logic              clip_inc;

    assign fifo_din      = {bus.req_x, bus.req_y, bus.req_colour};
    assign bus.req_ready = !fifo_full;

    plot_req_fifo #(.WIDTH(REQ_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (resetn),
        .push  (bus.req_valid && !fifo_full),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign last_x    = (cx == 3'(BOX_W - 1));
    assign last_pix  = last_x && (cy == 3'(BOX_H - 1));
    // Sums carry one extra bit so boxes hanging past the screen edge clip
    // instead of wrapping back onto it.
    assign sum_x     = {1'b0, bx} + {6'b0, cx};
    assign sum_y     = {1'b0, by} + {5'b0, cy};
    assign on_screen = (sum_x <= 9'(X_MAX)) && (sum_y <= 8'(Y_MAX));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= next_state;
    end

    // Popping on the last pixel chains boxes back to back with no idle cycle.
    always_comb begin
        next_state = state;
        fifo_pop   = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    next_state = S_DRAW;
                    fifo_pop   = 1'b1;
                end
            end
            S_DRAW: begin
                if (last_pix) begin
                    if (!fifo_empty) fifo_pop   = 1'b1;
                    else             next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        x_d      = vga_x_r;
        y_d      = vga_y_r;
        col_d    = vga_col_r;
        plot_d   = 1'b0;
        clip_inc = 1'b0;
        if (state == S_DRAW) begin
            x_d      = sum_x[X_W-1:0];
            y_d      = sum_y[Y_W-1:0];
            col_d    = bc;
            plot_d   = on_screen;
            clip_inc = !on_screen;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bx <= '0;
            by <= '0;
            bc <= '0;
            cx <= '0;
            cy <= '0;
        end else if (fifo_pop) begin
            {bx, by, bc} <= fifo_dout;
            cx <= '0;
            cy <= '0;
        end else if (state == S_DRAW) begin
            if (last_x) begin
                cx <= '0;
                cy <= cy + 1'b1;
            end else begin
                cx <= cx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vga_x_r    <= '0;
            vga_y_r    <= '0;
            vga_col_r  <= '0;
            vga_plot_r <= 1'b0;
            clip_count <= '0;
        end else begin
            vga_x_r    <= x_d;
            vga_y_r    <= y_d;
            vga_col_r  <= col_d;
            vga_plot_r <= plot_d;
            if (clip_inc && clip_count != 8'hFF) clip_count <= clip_count + 1'b1;
        end
    end

    assign bus.vga_x      = vga_x_r;
    assign bus.vga_y      = vga_y_r;
    assign bus.vga_colour = vga_col_r;
    assign bus.vga_plot   = vga_plot_r;
    assign busy           = (state == S_DRAW) || (fifo_count != '0);
    assign dbg_state      = state;

endmodule

// File: tb/tb_box_plot_sink.sv
// Bench for box_plot_sink: predicts every pixel write, its edge, ready, busy
// and clip count from the request stream.
module tb_box_plot_sink;
  import draw_pkg::*;

  localparam int BW    = 4;
  localparam int BH    = 4;
  localparam int DEPTH = 4;
  localparam int EW    = 19;  // {plot, x, y, colour}

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        busy;
  logic [7:0]  clip_count;
  draw_state_t dbg_state;

  box_plot_sink_if bus ();

  box_plot_sink #(.BOX_W(BW), .BOX_H(BH), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .bus        (bus),
    .busy       (busy),
    .clip_count (clip_count),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;
  int last_end = -100;
  int box_start;
  int exp_clip = 0;
  int pop_q[$];
  int exp_t[$];
  logic [EW-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  // A box starts two edges after acceptance, or right after the previous box.
  task automatic add_box(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    int start, px, py, idx;
    logic plot;
    start = (edge_n + 2 > last_end + 1) ? edge_n + 2 : last_end + 1;
    idx = 0;
    for (int yy = 0; yy < BH; yy++) begin
      for (int xx = 0; xx < BW; xx++) begin
        px = int'(x) + xx;
        py = int'(y) + yy;
        plot = (px <= 159) && (py <= 119);
        exp_q.push_back({plot, px[7:0], py[6:0], c});
        exp_t.push_back(start + idx);
        idx++;
      end
    end
    pop_q.push_back(start - 1);
    box_start = start;
    last_end  = start + BW * BH - 1;
  endtask

  task automatic model_clear();
    exp_q.delete();
    exp_t.delete();
    pop_q.delete();
    last_end = -100;
    exp_clip = 0;
  endtask

  task automatic step(output logic acc);
    logic [EW-1:0] e;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    acc = bus.req_valid && (pop_q.size() < DEPTH);
    x = bus.req_x;
    y = bus.req_y;
    c = bus.req_colour;
    @(posedge clk);
    edge_n++;
    if (acc) add_box(x, y, c);
    #2;
    if (exp_t.size() > 0 && exp_t[0] == edge_n) begin
      e = exp_q.pop_front();
      void'(exp_t.pop_front());
      check_eq("plot", bus.vga_plot, e[18]);
      check_eq("x", bus.vga_x, e[17:10]);
      check_eq("y", bus.vga_y, e[9:3]);
      check_eq("colour", bus.vga_colour, e[2:0]);
      if (!e[18] && exp_clip < 255) exp_clip++;
    end else begin
      check_eq("plot_idle", bus.vga_plot, 1'b0);
    end
    while (pop_q.size() > 0 && pop_q[0] <= edge_n) void'(pop_q.pop_front());
    check_eq("ready", bus.req_ready, pop_q.size() < DEPTH);
    check_eq("busy", busy, last_end > edge_n);
    check_eq("clip", clip_count, exp_clip);
  endtask

  task automatic send(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    logic acc;
    int tries;
    bus.req_valid  = 1'b1;
    bus.req_x      = x;
    bus.req_y      = y;
    bus.req_colour = c;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 200) begin
      step(acc);
      tries++;
    end
    check_eq("send_accept", acc, 1'b1);
    bus.req_valid = 1'b0;
  endtask

  task automatic idle(input int k);
    logic acc;
    bus.req_valid = 1'b0;
    repeat (k) step(acc);
  endtask

  task automatic reset_checks(input string tag);
    check_eq({tag, "_plot"}, bus.vga_plot, 1'b0);
    check_eq({tag, "_x"}, bus.vga_x, 8'd0);
    check_eq({tag, "_y"}, bus.vga_y, 7'd0);
    check_eq({tag, "_col"}, bus.vga_colour, 3'd0);
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_clip"}, clip_count, 8'd0);
  endtask

  initial begin
    logic acc;
    int s0;
    bus.req_valid  = 1'b0;
    bus.req_x      = '0;
    bus.req_y      = '0;
    bus.req_colour = '0;

    // Power-on reset
    repeat (2) @(posedge clk);
    #2;
    reset_checks("rst");
    resetn = 1'b1;
    #1;
    check_eq("rst_ready", bus.req_ready, 1'b1);

    // Single box, then drain
    send(8'd38, 7'd4, 3'd7);
    idle(22);

    // Six back-to-back: fills the FIFO, stalls the sender, hits full+pop edges
    for (int i = 0; i < 6; i++) send(8'(10 + 5 * i), 7'(20 + i), 3'(i));
    idle(100);

    // Bottom-right corner: 12 of 16 clipped
    send(8'd158, 7'd118, WHITE);
    idle(22);
    check_eq("clip_corner", clip_count, 8'd12);

    // Reset on the 7th pixel with two boxes queued
    send(8'd50, 7'd50, 3'd5);
    s0 = box_start;
    send(8'd60, 7'd60, 3'd6);
    send(8'd70, 7'd70, 3'd1);
    while (edge_n < s0 + 6) step(acc);
    #2;
    resetn = 1'b0;
    #1;
    reset_checks("midrst");
    model_clear();
    #1;
    resetn = 1'b1;
    #1;
    check_eq("midrst_ready", bus.req_ready, 1'b1);
    idle(40);

    // Two black boxes near the bottom edge, chained
    send(8'd118, 7'd97, BLACK);
    send(8'd123, 7'd100, BLACK);
    idle(40);

    // Random traffic, enough off-screen boxes to saturate the clip counter
    for (int i = 0; i < 600; i++) begin
      bus.req_valid  = ($urandom_range(0, 99) < 60);
      bus.req_x      = 8'($urandom_range(0, 255));
      bus.req_y      = 7'($urandom_range(0, 127));
      bus.req_colour = 3'($urandom_range(0, 7));
      step(acc);
    end
    idle(100);
    check_eq("clip_final", clip_count, exp_clip);
    check_eq("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
